// File: rtl/queen_solution_sender_if.sv
// queen_solution_sender_if: solver-side capture inputs and (row, column) valid/ready stream.
interface queen_solution_sender_if #(parameter int N = 8, parameter int IDX_W = 3);
  logic             in_done;
  logic             in_valid;
  logic [N-1:0]     in_row;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_row;
  logic [IDX_W-1:0] out_col;
  logic             out_last;
  logic             busy;
  logic             frame_done;
  logic             error;
  modport master (
    output in_done, in_valid, in_row, out_ready,
    input  out_valid, out_row, out_col, out_last, busy, frame_done, error
  );
  modport slave (
    input  in_done, in_valid, in_row, out_ready,
    output out_valid, out_row, out_col, out_last, busy, frame_done, error
  );
endinterface

// File: rtl/queen_solution_sender.sv
// queen_solution_sender: buffers one 8-queen board from the solver and streams it as (row, column) pairs.
module queen_solution_sender #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  queen_solution_sender_if.slave   s
);
  typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  state_t           state_q;
  logic [IDX_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [IDX_W-1:0] col_q [N];
  logic             busy_q, out_valid_q, frame_done_q, error_q;
  logic [IDX_W-1:0] enc;
  logic             bad;
  // lowest set bit wins, so scan from the top down
  always_comb begin
    enc = '0;
    for (int k = N - 1; k >= 0; k--) enc = s.in_row[k] ? k[IDX_W-1:0] : enc;
    bad = $countones(s.in_row) != 1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < N; i++) col_q[i] <= '0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s.in_done) begin
            state_q  <= CAPTURE;
            wr_ptr_q <= '0;
            error_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        CAPTURE: begin
          if (s.in_done) begin
            wr_ptr_q <= '0;
            error_q  <= 1'b1;
          end else if (s.in_valid) begin
            col_q[wr_ptr_q] <= enc;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
            if (bad) error_q <= 1'b1;
            if (wr_ptr_q == LAST) begin
              state_q     <= SEND;
              rd_ptr_q    <= '0;
              out_valid_q <= 1'b1;
            end
          end
        end
        SEND: begin
          if (s.in_valid || s.in_done) error_q <= 1'b1;
          if (s.out_ready) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            if (rd_ptr_q == LAST) begin
              state_q      <= IDLE;
              out_valid_q  <= 1'b0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign s.out_valid  = out_valid_q;
  assign s.out_row    = out_valid_q ? rd_ptr_q : '0;
  assign s.out_col    = out_valid_q ? col_q[rd_ptr_q] : '0;
  assign s.out_last   = out_valid_q && rd_ptr_q == LAST;
  assign s.busy       = busy_q;
  assign s.frame_done = frame_done_q;
  assign s.error      = error_q;
endmodule

// File: tb/tb_queen_solution_sender.sv
// tb_queen_solution_sender: randomized frames against a board-level model of the queen solution sender.
module tb_queen_solution_sender;
  localparam int N = 8, IDX_W = 3;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  queen_solution_sender_if #(.N(N), .IDX_W(IDX_W)) q ();
  queen_solution_sender #(.N(N), .IDX_W(IDX_W)) dut (.clk(clk), .reset_n(reset_n), .s(q.slave));
  int checks = 0, errors = 0;
  logic [7:0] rows [8];
  bit err_exp;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int model_col(input logic [7:0] r);
    int c = 0;
    if (r == 0) return 0;
    while (r % 2 == 0) begin
      r = r / 2;
      c++;
    end
    return c;
  endfunction
  function automatic bit model_bad(input logic [7:0] r);
    int n = 0;
    for (int i = 0; i < 8; i++) n += (r >> i) & 1;
    return n != 1;
  endfunction
  task automatic load_plan;
    logic [7:0] p [8] = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
    rows = p;
  endtask
  task automatic load_random;
    for (int i = 0; i < 8; i++)
      rows[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
  endtask
  // gap < 0 means a random 0..3 idle cycles before each beat
  task automatic capture(input int gap, input bit restart);
    err_exp = 1'b0;
    q.in_done = 1'b1;
    tick;
    q.in_done = 1'b0;
    check("busy_start", q.busy, 1);
    check("err_clear", q.error, 0);
    if (restart) begin
      for (int i = 0; i < 3; i++) begin
        q.in_valid = 1'b1;
        q.in_row = 8'($urandom);
        tick;
      end
      q.in_done = 1'b1;
      q.in_row = 8'h01;
      tick;
      q.in_done = 1'b0;
      q.in_valid = 1'b0;
      err_exp = 1'b1;
      check("restart_err", q.error, 1);
      check("restart_ov", q.out_valid, 0);
    end
    for (int i = 0; i < 8; i++) begin
      repeat (gap < 0 ? $urandom_range(0, 3) : gap) begin
        tick;
        check("gap_ov", q.out_valid, 0);
      end
      q.in_valid = 1'b1;
      q.in_row = rows[i];
      tick;
      q.in_valid = 1'b0;
      if (model_bad(rows[i])) err_exp = 1'b1;
      check("ov_after_beat", q.out_valid, i == 7);
    end
  endtask
  // mode 0: ready high, 1: 1-0-0 repeating, 2: random; abort_at>0 resets after that many handshakes
  task automatic receive(input int mode, input bit inject, input int abort_at);
    int idx = 0, c = 0;
    bit rdy;
    while (idx < 8 && c < 200) begin
      check("ov", q.out_valid, 1);
      check("row", q.out_row, idx);
      check("col", q.out_col, model_col(rows[idx]));
      check("last", q.out_last, idx == 7);
      check("busy", q.busy, 1);
      check("fd_low", q.frame_done, 0);
      rdy = mode == 0 ? 1'b1 : mode == 1 ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      q.out_ready = rdy;
      if (inject && c == 2) begin
        if ($urandom_range(0, 1)) q.in_valid = 1'b1; else q.in_done = 1'b1;
        q.in_row = 8'($urandom);
        err_exp = 1'b1;
      end
      tick;
      q.in_valid = 1'b0;
      q.in_done = 1'b0;
      q.out_ready = 1'b0;
      if (rdy) idx++;
      c++;
      if (abort_at > 0 && idx == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_ov", q.out_valid, 0);
        check("rst_busy", q.busy, 0);
        check("rst_row", q.out_row, 0);
        check("rst_col", q.out_col, 0);
        check("rst_last", q.out_last, 0);
        check("rst_fd", q.frame_done, 0);
        check("rst_err", q.error, 0);
        #7 reset_n = 1'b1;
        repeat (3) begin
          tick;
          check("post_rst_fd", q.frame_done, 0);
          check("post_rst_busy", q.busy, 0);
          check("post_rst_ov", q.out_valid, 0);
        end
        return;
      end
    end
    check("hs_count", idx, 8);
    check("fd", q.frame_done, 1);
    check("fd_ov", q.out_valid, 0);
    check("idle_busy", q.busy, 0);
    check("err_end", q.error, err_exp);
    tick;
    check("fd_pulse", q.frame_done, 0);
  endtask
  initial begin
    q.in_done = 1'b0;
    q.in_valid = 1'b0;
    q.in_row = '0;
    q.out_ready = 1'b0;
    repeat (2) tick;
    check("reset_ov", q.out_valid, 0);
    check("reset_busy", q.busy, 0);
    check("reset_err", q.error, 0);
    check("reset_fd", q.frame_done, 0);
    reset_n = 1'b1;
    tick;
    q.in_valid = 1'b1;
    q.in_row = 8'h03;
    tick;
    q.in_valid = 1'b0;
    check("idle_valid_busy", q.busy, 0);
    check("idle_valid_err", q.error, 0);
    load_plan;
    capture(0, 0);
    receive(0, 0, 0);
    capture(0, 0);
    receive(1, 0, 0);
    capture(2, 0);
    receive(0, 0, 0);
    load_plan;
    rows[2] = 8'h00;
    rows[5] = 8'h24;
    capture(0, 0);
    receive(2, 0, 0);
    load_plan;
    capture(0, 0);
    receive(0, 1, 0);
    capture(0, 1);
    receive(2, 0, 0);
    capture(-1, 0);
    receive(0, 0, 4);
    for (int f = 0; f < 25; f++) begin
      load_random;
      capture(-1, $urandom_range(0, 4) == 0);
      receive($urandom_range(0, 2), $urandom_range(0, 3) == 0, 0);
      repeat ($urandom_range(0, 2)) tick;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
